pc_fetch_queue: RTL

PC_FETCH_QUEUE -- requirements
Module: pc_fetch_queue

---
 rtl/pc_fetch_queue_pkg.sv | 26 ++
 rtl/fetch_entry_ram.sv | 86 ++++++++
 rtl/pc_fetch_queue.sv | 91 +++++++++
 3 files changed

// File: rtl/pc_fetch_queue_pkg.sv
// Shared widths, reset address and redirect-source helper for the fetch front end.
package pc_fetch_queue_pkg;

    localparam int          XLEN          = 32;
    localparam logic [31:0] CPU_RST_ADDR  = 32'h0000_0000;
    localparam int          INST_BYTE_NUM = 4;
    localparam logic [31:0] RST_ADDR      = CPU_RST_ADDR;
    localparam int          INST_BYTES    = INST_BYTE_NUM;
    localparam int          OT_DEPTH      = 4;

    typedef enum logic [1:0] {
        RD_NONE,
        RD_BJ,
        RD_MRET,
        RD_EXP
    } redir_e;

    // Exception beats mret, mret beats branch/jump.
    function automatic redir_e redir_sel(input logic exp_f, input logic mret_f, input logic bj_f);
        if (exp_f)  return RD_EXP;
        if (mret_f) return RD_MRET;
        if (bj_f)   return RD_BJ;
        return RD_NONE;
    endfunction

endpackage

// File: rtl/fetch_entry_ram.sv
// Outstanding-fetch entry store: head (pop), tail (alloc) and fill pointers over
// OT_DEPTH slots of {pc, inst, done, stale}.
module fetch_entry_ram #(
    parameter int XLEN     = pc_fetch_queue_pkg::XLEN,
    parameter int OT_DEPTH = pc_fetch_queue_pkg::OT_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alloc_i,
    input  logic [XLEN-1:0]            alloc_pc_i,
    input  logic                       fill_i,
    input  logic [XLEN-1:0]            fill_data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [XLEN-1:0]            head_pc_o,
    output logic [XLEN-1:0]            head_inst_o,
    output logic                       head_done_o,
    output logic                       head_stale_o,
    output logic [$clog2(OT_DEPTH):0]  cnt_o
);
    import pc_fetch_queue_pkg::*;

    localparam int PW = $clog2(OT_DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0]     pc_q   [OT_DEPTH];
    logic [XLEN-1:0]     inst_q [OT_DEPTH];
    logic [OT_DEPTH-1:0] done_q, done_d, stale_q, stale_d;
    logic [PW-1:0]       head_q, head_d, tail_q, tail_d, fill_q, fill_d;
    logic [CW-1:0]       cnt_q, cnt_d, ucnt_q, ucnt_d;
    logic                do_alloc, do_fill, do_pop;

    // Entries fill strictly in order, so [head, fill) are done and [fill, tail) are not.
    assign do_alloc = alloc_i && !flush_i && (cnt_q != CW'(OT_DEPTH));
    assign do_fill  = fill_i && (ucnt_q != '0);
    assign do_pop   = pop_i && !flush_i && (cnt_q != '0);

    always_comb begin
        done_d  = done_q;
        stale_d = flush_i ? (stale_q | ~done_q) : stale_q;
        if (do_alloc) begin
            done_d[tail_q]  = 1'b0;
            stale_d[tail_q] = 1'b0;
        end
        if (do_fill) done_d[fill_q] = 1'b1;

        tail_d = tail_q + PW'(do_alloc);
        fill_d = fill_q + PW'(do_fill);
        ucnt_d = ucnt_q + CW'(do_alloc) - CW'(do_fill);
        // Flush drops every done entry; the undone ones stay until their response lands.
        head_d = flush_i ? fill_q : head_q + PW'(do_pop);
        cnt_d  = flush_i ? ucnt_q : cnt_q + CW'(do_alloc) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
            ucnt_q  <= '0;
            done_q  <= '0;
            stale_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            ucnt_q  <= ucnt_d;
            done_q  <= done_d;
            stale_q <= stale_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_alloc) pc_q[tail_q]   <= alloc_pc_i;
        if (do_fill)  inst_q[fill_q] <= fill_data_i;
    end

    assign head_pc_o    = pc_q[head_q];
    assign head_inst_o  = inst_q[head_q];
    assign head_done_o  = (cnt_q != '0) && done_q[head_q];
    assign head_stale_o = stale_q[head_q];
    assign cnt_o        = cnt_q;

endmodule

// File: rtl/pc_fetch_queue.sv
// Fetch PC generator with redirect muxing, request handshake and an in-order
// outstanding-fetch queue that drops responses belonging to flushed requests.
module pc_fetch_queue #(
    parameter int              XLEN       = pc_fetch_queue_pkg::XLEN,
    parameter logic [XLEN-1:0] RST_ADDR   = XLEN'(pc_fetch_queue_pkg::RST_ADDR),
    parameter int              INST_BYTES = pc_fetch_queue_pkg::INST_BYTES,
    parameter int              OT_DEPTH   = pc_fetch_queue_pkg::OT_DEPTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic            exp_flag,
    input  logic [XLEN-1:0] exp_addr,
    input  logic            mret_flag,
    input  logic [XLEN-1:0] mret_addr,
    input  logic            bj_flag,
    input  logic [XLEN-1:0] bj_addr,
    input  logic            pipe_stall,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [XLEN-1:0] req_addr,
    input  logic            rsp_valid,
    input  logic [XLEN-1:0] rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic [XLEN-1:0] pc_o
);
    import pc_fetch_queue_pkg::*;

    localparam int CW = $clog2(OT_DEPTH) + 1;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] head_pc, head_inst;
    logic            head_done, head_stale;
    logic [CW-1:0]   cnt;
    redir_e          redir;
    logic            flush, full, accept, pop;

    assign redir  = redir_sel(exp_flag, mret_flag, bj_flag);
    assign flush  = (redir != RD_NONE);
    assign full   = (cnt == CW'(OT_DEPTH));

    assign req_valid  = !rst && if_valid && !pipe_stall && !flush && !full;
    assign req_addr   = pc_q;
    assign accept     = req_valid && req_ready;

    assign inst_valid = !rst && !flush && head_done && !head_stale;
    assign inst       = rst ? '0 : head_inst;
    assign inst_pc    = rst ? '0 : head_pc;
    // Stale heads retire on their own the cycle after their response lands.
    assign pop        = (inst_valid && inst_ready) || (head_done && head_stale);

    always_comb begin
        pc_d = pc_q;
        case (redir)
            RD_EXP:  pc_d = exp_addr;
            RD_MRET: pc_d = mret_addr;
            RD_BJ:   pc_d = bj_addr;
            default: if (accept) pc_d = pc_q + XLEN'(INST_BYTES);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) pc_q <= RST_ADDR;
        else     pc_q <= pc_d;
    end

    assign pc_o = pc_q;

    fetch_entry_ram #(
        .XLEN     (XLEN),
        .OT_DEPTH (OT_DEPTH)
    ) u_ram (
        .clk          (clk),
        .rst          (rst),
        .alloc_i      (accept),
        .alloc_pc_i   (pc_q),
        .fill_i       (rsp_valid),
        .fill_data_i  (rsp_data),
        .pop_i        (pop),
        .flush_i      (flush),
        .head_pc_o    (head_pc),
        .head_inst_o  (head_inst),
        .head_done_o  (head_done),
        .head_stale_o (head_stale),
        .cnt_o        (cnt)
    );

endmodule
